pipeline_hazard_controller: RTL and testbench

//  Stall/flush sequencer for the 5-stage MIPS pipeline; sits beside the EX forwarding mux logic.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/mul_occupancy_counter.sv | 39 +++
 rtl/pipeline_hazard_controller.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         DEFAULT_MUL_LATENCY = 4;

endpackage

// File: rtl/mul_occupancy_counter.sv
// Load/decrement counter tracking the remaining EX cycles of a multi-cycle MUL op.
module mul_occupancy_counter
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    localparam int CW = $clog2(MUL_LATENCY) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            // The start cycle itself is MUL cycle 1, so only LATENCY-1 cycles remain.
            cnt_d = CW'(MUL_LATENCY - 1);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and multi-cycle MUL occupancy of EX, plus a saturating stall-cycle counter.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RSAddr_i,
    input  logic [4:0]       ID_RTAddr_i,
    input  logic             ID_UsesRT_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_RTAddr_i,
    input  logic             EX_MulStart_i,
    input  logic             EX_BranchTaken_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IDEX_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Flush_o,
    output logic             EXMEM_Flush_o,
    output logic             MulBusy_o,
    output logic             MulDone_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    hz_state_e        state_q, state_d;
    logic             mul_load, mul_dec, mul_last;
    logic             load_use_hit;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mul_occupancy_counter #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(mul_load),
        .dec_i (mul_dec),
        .last_o(mul_last)
    );

    assign load_use_hit = EX_MemRead_i && (EX_RTAddr_i != REG_ZERO) &&
                          ((EX_RTAddr_i == ID_RSAddr_i) ||
                           (ID_UsesRT_i && (EX_RTAddr_i == ID_RTAddr_i)));

    always_comb begin
        state_d       = state_q;
        mul_load      = 1'b0;
        mul_dec       = 1'b0;
        PC_Write_o    = 1'b1;
        IFID_Write_o  = 1'b1;
        IDEX_Write_o  = 1'b1;
        IFID_Flush_o  = 1'b0;
        IDEX_Flush_o  = 1'b0;
        EXMEM_Flush_o = 1'b0;
        MulBusy_o     = 1'b0;
        MulDone_o     = 1'b0;

        if (rst_i) begin
            // Freeze and bubble the whole front end while reset is held.
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Write_o  = 1'b0;
            IFID_Flush_o  = 1'b1;
            IDEX_Flush_o  = 1'b1;
            EXMEM_Flush_o = 1'b1;
            state_d       = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (EX_MulStart_i) begin
                        PC_Write_o    = 1'b0;
                        IFID_Write_o  = 1'b0;
                        IDEX_Write_o  = 1'b0;
                        EXMEM_Flush_o = 1'b1;
                        MulBusy_o     = 1'b1;
                        mul_load      = 1'b1;
                        state_d       = MUL;
                    end else if (EX_BranchTaken_i) begin
                        // A load-use hit here is on the wrong path, so it is not stalled.
                        IFID_Flush_o = 1'b1;
                        IDEX_Flush_o = 1'b1;
                    end else if (load_use_hit) begin
                        PC_Write_o   = 1'b0;
                        IFID_Write_o = 1'b0;
                        IDEX_Flush_o = 1'b1;
                    end
                end
                MUL: begin
                    PC_Write_o    = 1'b0;
                    IFID_Write_o  = 1'b0;
                    IDEX_Write_o  = 1'b0;
                    EXMEM_Flush_o = 1'b1;
                    MulBusy_o     = 1'b1;
                    mul_dec       = 1'b1;
                    if (mul_last) begin
                        MulDone_o = 1'b1;
                        state_d   = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_Write_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MUL_LATENCY=4, CNT_W=4).
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;

    // Output vector order: {PC_W, IFID_W, IDEX_W, IFID_F, IDEX_F, EXMEM_F, Busy, Done}
    localparam logic [7:0] O_RESET  = 8'b000_111_00;
    localparam logic [7:0] O_NORMAL = 8'b111_000_00;
    localparam logic [7:0] O_LDUSE  = 8'b001_010_00;
    localparam logic [7:0] O_BRANCH = 8'b111_110_00;
    localparam logic [7:0] O_MUL    = 8'b000_001_10;
    localparam logic [7:0] O_MULEND = 8'b000_001_11;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, ex_mul_start, ex_branch;
    logic             pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f, busy, done;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       outs;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller #(
        .MUL_LATENCY(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ID_RSAddr_i     (id_rs),
        .ID_RTAddr_i     (id_rt),
        .ID_UsesRT_i     (id_uses_rt),
        .EX_MemRead_i    (ex_mem_read),
        .EX_RTAddr_i     (ex_rt),
        .EX_MulStart_i   (ex_mul_start),
        .EX_BranchTaken_i(ex_branch),
        .PC_Write_o      (pc_w),
        .IFID_Write_o    (ifid_w),
        .IDEX_Write_o    (idex_w),
        .IFID_Flush_o    (ifid_f),
        .IDEX_Flush_o    (idex_f),
        .EXMEM_Flush_o   (exmem_f),
        .MulBusy_o       (busy),
        .MulDone_o       (done),
        .StallCnt_o      (stall_cnt)
    );

    assign outs = {pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, then let the combinational outputs settle.
    task automatic drive(input logic r, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic ms, input logic br);
        rst          = r;
        ex_mem_read  = mr;
        ex_rt        = ert;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        ex_mul_start = ms;
        ex_branch    = br;
        #1;
    endtask

    initial begin
        // Reset held: writes off, flushes on.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_outs", 16'(outs), 16'(O_RESET));
        check("reset_cnt", 16'(stall_cnt), 16'd0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_outs", 16'(outs), 16'(O_NORMAL));

        // T1: lw $2 in EX, add rs=$2 in ID -> single bubble.
        tick();
        drive(0, 1, 5'd2, 5'd2, 5'd9, 0, 0, 0);
        check("t1_rs_hit", 16'(outs), 16'(O_LDUSE));
        check("t1_cnt_before", 16'(stall_cnt), 16'd0);
        tick();
        drive(0, 0, 5'd2, 5'd2, 5'd9, 0, 0, 0);
        check("t1_resume", 16'(outs), 16'(O_NORMAL));
        check("t1_cnt_after", 16'(stall_cnt), 16'd1);

        // rt match with ID_UsesRT set also stalls.
        tick();
        drive(0, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0);
        check("t1_rt_hit", 16'(outs), 16'(O_LDUSE));

        // T2: $0 destination and rt-unused never stall.
        tick();
        drive(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        check("t2_zero_reg", 16'(outs), 16'(O_NORMAL));
        check("t2_cnt", 16'(stall_cnt), 16'd2);
        tick();
        drive(0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
        check("t2_rt_unused", 16'(outs), 16'(O_NORMAL));

        // T3: branch beats a simultaneous load-use hit.
        tick();
        drive(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1);
        check("t3_branch_vs_lu", 16'(outs), 16'(O_BRANCH));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("t3_cnt", 16'(stall_cnt), 16'd2);

        // T4: MUL occupies EX for 4 cycles; branch and load-use during MUL are ignored.
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        check("t4_mul_c1", 16'(outs), 16'(O_MUL));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        check("t4_mul_c2_branch", 16'(outs), 16'(O_MUL));
        tick();
        drive(0, 1, 5'd6, 5'd6, 5'd0, 0, 1, 1);
        check("t4_mul_c3_lu", 16'(outs), 16'(O_MUL));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        check("t4_mul_c4_done", 16'(outs), 16'(O_MULEND));
        tick();
        // Back-to-back MUL right after exit restarts the full sequence.
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        check("t4_cnt_plus4", 16'(stall_cnt), 16'd6);
        check("t4_b2b_c1", 16'(outs), 16'(O_MUL));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("t4_b2b_c2", 16'(outs), 16'(O_MUL));
        tick();
        check("t4_b2b_c3", 16'(outs), 16'(O_MUL));
        tick();
        check("t4_b2b_c4", 16'(outs), 16'(O_MULEND));
        tick();
        check("t4_b2b_exit", 16'(outs), 16'(O_NORMAL));
        check("t4_b2b_cnt", 16'(stall_cnt), 16'd10);

        // T5: reset at MUL cycle 2 aborts without a done pulse.
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        check("t5_mul_c1", 16'(outs), 16'(O_MUL));
        tick();
        drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("t5_reset_outs", 16'(outs), 16'(O_RESET));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("t5_after_reset_run", 16'(outs), 16'(O_NORMAL));
        check("t5_cnt_cleared", 16'(stall_cnt), 16'd0);

        // T6: 20 cycles of load-use stall saturate the 4-bit counter at 15.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0);
            check($sformatf("t6_outs_%0d", i), 16'(outs), 16'(O_LDUSE));
            check($sformatf("t6_cnt_%0d", i), 16'(stall_cnt), 16'((i < 15) ? i : 15));
            tick();
        end
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("t6_cnt_saturated", 16'(stall_cnt), 16'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
